// File: rtl/systolic_ctrl_if.sv
// Bus bundle between systolic_ctrl and its operand buffers, the tpumac array and the result consumer.
interface systolic_ctrl_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
);
  localparam int AW = $clog2(DIM);

  logic                        buf_rd;
  logic [AW-1:0]               buf_addr;
  logic [DIM-1:0][BITS_AB-1:0] a_col;
  logic [DIM-1:0][BITS_AB-1:0] b_row;

  logic                        arr_en;
  logic                        arr_wren;
  logic [AW-1:0]               arr_crow;
  logic [DIM-1:0][BITS_C-1:0]  arr_cin;
  logic [DIM-1:0][BITS_AB-1:0] arr_a;
  logic [DIM-1:0][BITS_AB-1:0] arr_b;
  logic [DIM-1:0][BITS_C-1:0]  arr_cout;

  logic                        out_valid;
  logic                        out_ready;
  logic [AW-1:0]               out_row;
  logic [DIM-1:0][BITS_C-1:0]  out_data;

  modport master (
    output buf_rd, buf_addr,
    input  a_col, b_row,
    output arr_en, arr_wren, arr_crow, arr_cin, arr_a, arr_b,
    input  arr_cout,
    output out_valid, out_row, out_data,
    input  out_ready
  );

  modport slave (
    input  buf_rd, buf_addr,
    output a_col, b_row,
    input  arr_en, arr_wren, arr_crow, arr_cin, arr_a, arr_b,
    output arr_cout,
    input  out_valid, out_row, out_data,
    output out_ready
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for one DIM x DIM multiply on the tpumac array: clear, load, skewed feed, row output.
// Optional macro SYSTOLIC_CTRL_ACCUM_EN adds an accum input that skips the C clear.
module systolic_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  input  logic            accum,
`endif
  output logic            busy,
  output logic            done,
  systolic_ctrl_if.master bus
);
  localparam int AW        = $clog2(DIM);
  localparam int CW        = $clog2(3 * DIM);
  localparam int FEED_LAST = 3 * DIM - 3;
  localparam int NS        = DIM * (DIM - 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FEED,
    S_OUT,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NS-1:0][BITS_AB-1:0] sk_a_q, sk_a_d;
  logic [NS-1:0][BITS_AB-1:0] sk_b_q, sk_b_d;
  logic [DIM-1:0][BITS_AB-1:0] fetch_a, fetch_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sk_a_q  <= '0;
      sk_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sk_a_q  <= sk_a_d;
      sk_b_q  <= sk_b_d;
    end
  end

  // Lane i of the skew store is a triangular chain of i stages starting at index i*(i-1)/2.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sk_a_d        = sk_a_q;
    sk_b_d        = sk_b_q;
    fetch_a       = '0;
    fetch_b       = '0;
    busy          = 1'b0;
    done          = 1'b0;
    bus.buf_rd    = 1'b0;
    bus.buf_addr  = '0;
    bus.arr_en    = 1'b0;
    bus.arr_wren  = 1'b0;
    bus.arr_crow  = '0;
    bus.arr_cin   = {DIM * BITS_C{1'b0}};
    bus.arr_a     = '0;
    bus.arr_b     = '0;
    bus.out_valid = 1'b0;
    bus.out_row   = '0;
    bus.out_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          sk_a_d = '0;
          sk_b_d = '0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
          state_d = accum ? S_LOAD : S_CLEAR;
`else
          state_d = S_CLEAR;
`endif
        end
      end

      S_CLEAR: begin
        busy         = 1'b1;
        bus.arr_wren = 1'b1;
        bus.arr_crow = AW'(cnt_q);
        if (cnt_q == CW'(DIM - 1)) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOAD: begin
        busy       = 1'b1;
        bus.buf_rd = 1'b1;
        cnt_d      = '0;
        state_d    = S_FEED;
      end

      S_FEED: begin
        busy       = 1'b1;
        bus.arr_en = 1'b1;
        if (cnt_q < CW'(DIM - 1)) begin
          bus.buf_rd   = 1'b1;
          bus.buf_addr = AW'(cnt_q + CW'(1));
        end
        if (cnt_q < CW'(DIM)) begin
          fetch_a = bus.a_col;
          fetch_b = bus.b_row;
        end
        bus.arr_a[0] = fetch_a[0];
        bus.arr_b[0] = fetch_b[0];
        for (int i = 1; i < DIM; i++) begin
          sk_a_d[i * (i - 1) / 2] = fetch_a[i];
          sk_b_d[i * (i - 1) / 2] = fetch_b[i];
          for (int s = 1; s < i; s++) begin
            sk_a_d[i * (i - 1) / 2 + s] = sk_a_q[i * (i - 1) / 2 + s - 1];
            sk_b_d[i * (i - 1) / 2 + s] = sk_b_q[i * (i - 1) / 2 + s - 1];
          end
          bus.arr_a[i] = sk_a_q[i * (i - 1) / 2 + i - 1];
          bus.arr_b[i] = sk_b_q[i * (i - 1) / 2 + i - 1];
        end
        if (cnt_q == CW'(FEED_LAST)) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.arr_crow  = AW'(cnt_q);
        bus.out_row   = AW'(cnt_q);
        bus.out_data  = bus.arr_cout;
        if (bus.out_ready) begin
          if (cnt_q == CW'(DIM - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: operand buffer and array models plus a plain matrix-product reference.
module tb_systolic_ctrl;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic accum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  int                 mem_a [DIM][DIM];
  int                 mem_b [DIM][DIM];
  logic [BITS_C-1:0]  ref_c [DIM][DIM];
  logic [BITS_AB-1:0] pa    [DIM][DIM];
  logic [BITS_AB-1:0] pb    [DIM][DIM];
  logic [BITS_C-1:0]  cacc  [DIM][DIM];

  systolic_ctrl_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) bus ();

  systolic_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    .accum (accum),
`endif
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Operand buffers: one-cycle synchronous read of column k of A and row k of B.
  always @(posedge clk) begin
    if (rst) begin
      bus.a_col <= '0;
      bus.b_row <= '0;
    end else if (bus.buf_rd) begin
      for (int i = 0; i < DIM; i++) begin
        bus.a_col[i] <= BITS_AB'(mem_a[i][bus.buf_addr]);
        bus.b_row[i] <= BITS_AB'(mem_b[bus.buf_addr][i]);
      end
    end
  end

  // Output-stationary array: operands ripple right/down every cycle, MAC only while enabled.
  always @(posedge clk) begin : array_model
    int ain [DIM][DIM];
    int bin [DIM][DIM];
    for (int i = 0; i < DIM; i++) begin
      ain[i][0] = int'($signed(bus.arr_a[i]));
      bin[0][i] = int'($signed(bus.arr_b[i]));
      for (int j = 1; j < DIM; j++) begin
        ain[i][j] = int'($signed(pa[i][j-1]));
        bin[j][i] = int'($signed(pb[j-1][i]));
      end
    end
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        pa[i][j] <= BITS_AB'(ain[i][j]);
        pb[i][j] <= BITS_AB'(bin[i][j]);
        if (bus.arr_en)
          cacc[i][j] <= cacc[i][j] + BITS_C'(ain[i][j] * bin[i][j]);
        else if (bus.arr_wren && int'(bus.arr_crow) == i)
          cacc[i][j] <= bus.arr_cin[j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DIM; j++) bus.arr_cout[j] = cacc[bus.arr_crow][j];
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setMats(input int kind);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        case (kind)
          0: begin mem_a[i][j] = (i == j) ? 1 : 0; mem_b[i][j] = i * 8 + j; end
          1: begin mem_a[i][j] = 2; mem_b[i][j] = 3; end
          2: begin
            mem_a[i][j] = int'($urandom_range(255, 0)) - 128;
            mem_b[i][j] = int'($urandom_range(255, 0)) - 128;
          end
          3: begin mem_a[i][j] = 1; mem_b[i][j] = 1; end
          4: begin mem_a[i][j] = -128; mem_b[i][j] = -128; end
          default: begin mem_a[i][j] = (i == j) ? 1 : 0; mem_b[i][j] = (i == j) ? 1 : 0; end
        endcase
      end
    end
  endtask

  task automatic computeRef(input bit acc);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        int s;
        s = acc ? int'(ref_c[i][j]) : 0;
        for (int k = 0; k < DIM; k++) s += mem_a[i][k] * mem_b[k][j];
        ref_c[i][j] = BITS_C'(s);
      end
    end
  endtask

  // Called at a falling edge with the DUT idle; that cycle is cycle 0 of the run.
  task automatic applyStimulus(input bit stall, input bit repulse, input bit acc);
    int row_exp  = 0;
    int en_cnt   = 0;
    int rd_cnt   = 0;
    int first_v  = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int last_hs  = -1;
    int pat      = 0;
    bit rd_ok    = 1'b1;
    bit prev_stall = 1'b0;
    bit rdy;
    logic [2:0] held_row = '0;
    logic [DIM*BITS_C-1:0] held_data = '0;
    logic [DIM*BITS_C-1:0] exp_row;
    computeRef(acc);
    start = 1'b1;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accum = acc;
`endif
    bus.out_ready = 1'b0;
    for (int cyc = 1; cyc <= 400 && (done_cyc < 0 || cyc <= done_cyc + 1); cyc++) begin
      @(negedge clk);
      start = repulse && (cyc == 10 || cyc == 20);
      if (bus.arr_en) en_cnt++;
      if (bus.buf_rd) begin
        if (int'(bus.buf_addr) != rd_cnt) rd_ok = 1'b0;
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) checkOutput("busy_after_done", busy, 0);
      rdy = 1'b0;
      if (bus.out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (prev_stall) begin
          checkOutput("stall_row_stable", bus.out_row, held_row);
          checkOutput("stall_data_stable", bus.out_data, held_data);
        end
        rdy = stall ? (pat % 4 == 0 || pat % 4 == 3) : 1'b1;
        pat++;
        if (rdy) begin
          if (row_exp < DIM) begin
            for (int j = 0; j < DIM; j++) exp_row[j*BITS_C +: BITS_C] = ref_c[row_exp][j];
          end else begin
            exp_row = '1;
          end
          checkOutput($sformatf("row%0d_index", row_exp), bus.out_row, row_exp[2:0]);
          checkOutput($sformatf("row%0d_data", row_exp), bus.out_data, exp_row);
          row_exp++;
          last_hs = cyc;
        end
        prev_stall = !rdy;
        held_row   = bus.out_row;
        held_data  = bus.out_data;
      end else begin
        prev_stall = 1'b0;
      end
      bus.out_ready = rdy;
    end
    checkOutput("done_seen_in_budget", done_cyc >= 0, 1);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("rows_out", row_exp, DIM);
    checkOutput("arr_en_cycles", en_cnt, 3 * DIM - 2);
    checkOutput("buf_read_seq", {rd_ok, 8'(rd_cnt)}, {1'b1, 8'(DIM)});
    checkOutput("first_valid_cycle", first_v, acc ? 3 * DIM : 4 * DIM);
    checkOutput("done_after_last_row", done_cyc, last_hs + 1);
    if (!stall) checkOutput("done_cycle", done_cyc, (acc ? 4 * DIM : 5 * DIM));
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accum = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_busy_done", {busy, done}, 0);
    checkOutput("reset_ctrl", {bus.buf_rd, bus.buf_addr, bus.arr_en, bus.arr_wren,
                               bus.arr_crow, bus.out_valid, bus.out_row}, 0);
    checkOutput("reset_arr_edges", {bus.arr_a, bus.arr_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] identity x ramp");
    setMats(0); applyStimulus(1'b0, 1'b0, 1'b0);
    $display("[TB] constant 2 x 3");
    setMats(1); applyStimulus(1'b0, 1'b0, 1'b0);
    $display("[TB] random with stalls and ignored restarts");
    setMats(2); applyStimulus(1'b1, 1'b1, 1'b0);
    $display("[TB] back-to-back random run");
    setMats(2); applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] reset during feed");
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("in_feed_before_reset", bus.arr_en, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_reset_busy_done", {busy, done}, 0);
    checkOutput("midrun_reset_ctrl", {bus.buf_rd, bus.buf_addr, bus.arr_en, bus.arr_wren,
                                      bus.arr_crow, bus.out_valid, bus.out_row}, 0);
    checkOutput("midrun_reset_data", {bus.arr_a, bus.arr_b}, 0);
    checkOutput("midrun_reset_out", bus.out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("no_done_after_reset", {busy, done}, 0);
    setMats(3); applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] -128 x -128 wrap");
    setMats(4); applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef SYSTOLIC_CTRL_ACCUM_EN
    $display("[TB] accumulate identity twice");
    setMats(5); applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
